// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and keeps one request in flight to instruction memory.
// Optional combinational response bypass is enabled by defining FETCH_BYPASS_EN.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb,
    input  logic [63:0] jb_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [63:0] current_pc,
    output logic [31:0] inst,
    output logic        waiting
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_pc;
    logic [63:0] w_pc_next;
    logic [63:0] r_pc_buf;
    logic [63:0] w_pc_buf_next;
    logic [31:0] r_inst_buf;
    logic [31:0] w_inst_buf_next;

    logic [63:0] w_jb_pc;
    logic [63:0] w_pc_inc;

    // Redirect targets are forced onto a word boundary; increment wraps modulo 2^64.
    assign w_jb_pc  = {jb_target[63:2], 2'b00};
    assign w_pc_inc = r_pc + 64'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_pc_buf   <= RESET_PC;
            r_inst_buf <= NOP_INST;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pc_buf   <= w_pc_buf_next;
            r_inst_buf <= w_inst_buf_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_pc_buf_next   = r_pc_buf;
        w_inst_buf_next = r_inst_buf;

        case (r_state)
            S_REQ: begin
                if (jb) begin
                    w_pc_next = w_jb_pc;
                    // A grant this cycle means the old-address request is already in flight.
                    w_state_next = imem_gnt ? S_DISCARD : S_REQ;
                end else if (imem_gnt) begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (jb) begin
                    w_pc_next    = w_jb_pc;
                    w_state_next = imem_rvalid ? S_REQ : S_DISCARD;
                end else if (imem_rvalid) begin
                    w_pc_buf_next   = r_pc;
                    w_inst_buf_next = imem_rdata;
`ifdef FETCH_BYPASS_EN
                    if (!stall) begin
                        w_pc_next    = w_pc_inc;
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_HOLD;
                    end
`else
                    w_state_next = S_HOLD;
`endif
                end
            end

            S_DISCARD: begin
                if (jb) begin
                    w_pc_next = w_jb_pc;
                end
                if (imem_rvalid) begin
                    w_state_next = S_REQ;
                end
            end

            S_HOLD: begin
                if (jb) begin
                    w_pc_next    = w_jb_pc;
                    w_state_next = S_REQ;
                end else if (!stall) begin
                    w_pc_next    = w_pc_inc;
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_pc;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    // Present the response in its arrival cycle unless a redirect squashes it.
    assign w_bypass = (r_state == S_WAIT) && imem_rvalid && !jb;

    always_comb begin
        current_pc = r_pc_buf;
        inst       = r_inst_buf;
        waiting    = (r_state != S_HOLD);
        if (w_bypass) begin
            current_pc = r_pc;
            inst       = imem_rdata;
            waiting    = 1'b0;
        end
    end
`else
    assign current_pc = r_pc_buf;
    assign inst       = r_inst_buf;
    assign waiting    = (r_state != S_HOLD);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder plus a program-order PC model
// predicts every request address and every presented pc/instruction pair.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP    = 32'h00000013;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_PERIOD = 2;
`else
    localparam int EXP_PERIOD = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jb;
    logic [63:0] jb_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] current_pc;
    logic [31:0] inst;
    logic        waiting;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jb          (jb),
        .jb_target   (jb_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .current_pc  (current_pc),
        .inst        (inst),
        .waiting     (waiting)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: architectural next-fetch PC and the memory responder.
    logic [63:0] exp_pc;
    logic        outst;
    int          cnt;
    logic [63:0] gaddr;
    logic        hold_expect;
    int          lat_fixed;
    int          pg, pj, ps;
    int          cyc;
    int          last_pres;
    int          period;
    int          stuck;
    int          n_pres;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory image: distinct word per aligned address, f(0) = 32'h00500093.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h00500093;
    endfunction

    task automatic drive_inputs();
        stall    = ($urandom_range(99) < ps);
        jb       = ($urandom_range(99) < pj);
        imem_gnt = ($urandom_range(99) < pg);
        case ($urandom_range(3))
            0:       jb_target = {$urandom, $urandom};
            1:       jb_target = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            2:       jb_target = 64'($urandom_range(255));
            default: jb_target = 64'h1000 + 64'($urandom_range(63));
        endcase
        if (outst && cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(gaddr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (outst) cnt--;
        end
    endtask

    // Entered at a negedge with inputs stable; leaves at the next negedge.
    task automatic cycle();
        logic        s_pres, s_req, s_jb, s_stall, s_gnt, s_rv;
        logic [63:0] s_addr, s_tgt;
        if (imem_req) begin
            chk("req_addr", imem_addr, exp_pc);
            chk("single_outstanding", 64'(outst), 64'd0);
        end
        if (!waiting) begin
            chk("current_pc", current_pc, exp_pc);
            chk("inst", 64'(inst), 64'(mem_word(exp_pc)));
            chk("req_idle_when_valid", 64'(imem_req), 64'd0);
            n_pres++;
            if (last_pres >= 0) period = cyc - last_pres;
            last_pres = cyc;
            stuck = 0;
        end else begin
            stuck++;
        end
        if (hold_expect) chk("stall_holds", 64'(waiting), 64'd0);
        if (stuck > 80) begin
            chk("progress_timeout", 64'(stuck), 64'd0);
            stuck = 0;
        end
        s_pres = !waiting; s_req = imem_req; s_addr = imem_addr;
        s_jb = jb; s_tgt = jb_target; s_stall = stall; s_gnt = imem_gnt; s_rv = imem_rvalid;

        @(posedge clk);
        #1;
        if (s_jb)                    exp_pc = {s_tgt[63:2], 2'b00};
        else if (s_pres && !s_stall) exp_pc = exp_pc + 64'd4;
        if (s_rv) outst = 1'b0;
        if (s_req && s_gnt) begin
            outst = 1'b1;
            gaddr = s_addr;
            cnt   = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
        end
        hold_expect = s_pres && s_stall && !s_jb;
        cyc++;
        drive_inputs();
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_pc      = RST_PC;
        outst       = 1'b0;
        cnt         = 0;
        gaddr       = '0;
        hold_expect = 1'b0;
        last_pres   = -1;
        period      = 0;
        stuck       = 0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; jb = 1'b0; jb_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        cyc = 0; n_pres = 0; lat_fixed = 1; pg = 100; pj = 0; ps = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_waiting", 64'(waiting), 64'd1);
        chk("rst_pc", current_pc, RST_PC);
        chk("rst_inst", 64'(inst), 64'(NOP));
        chk("rst_req", 64'(imem_req), 64'd1);
        chk("rst_addr", imem_addr, RST_PC);

        // Back-to-back fetch with immediate grant and one-cycle response.
        rst = 1'b0;
        drive_inputs();
        repeat (30) cycle();
        chk("throughput_period", 64'(period), 64'(EXP_PERIOD));
        chk("presented_any", 64'(n_pres > 5), 64'd1);

        // Mixed random traffic, then redirect-heavy traffic.
        lat_fixed = 0; pg = 60; pj = 8; ps = 30;
        repeat (3000) cycle();
        pj = 35; ps = 20; pg = 40;
        repeat (2000) cycle();

        // Asynchronous reset landing while a response is outstanding.
        pj = 0; ps = 0; pg = 100; lat_fixed = 3;
        for (int i = 0; i < 40 && !outst; i++) cycle();
        chk("reached_wait", 64'(outst), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_waiting", 64'(waiting), 64'd1);
        chk("arst_pc", current_pc, RST_PC);
        chk("arst_inst", 64'(inst), 64'(NOP));
        chk("arst_req", 64'(imem_req), 64'd1);
        chk("arst_addr", imem_addr, RST_PC);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        lat_fixed = 0; pg = 70; pj = 10; ps = 25;
        drive_inputs();
        repeat (1500) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the RV64I pipeline. It owns the PC and issues single-outstanding requests to instruction memory. It drives current_pc/inst and the waiting qualifier consumed by the IF/ID register, and redirects on a taken jump/branch (jb).
Single request in flight; responses belonging to a squashed fetch are discarded.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
NOP_INST, 32'h00000013, instruction value driven on inst at reset (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall  in  1  downstream hazard stall; holds the presented instruction
jb  in  1  taken jump/branch redirect
jb_target  in  64  redirect address
imem_req  out  1  request valid to instruction memory
imem_addr  out  64  request address (word aligned)
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction word
current_pc  out  64  PC of the presented instruction
inst  out  32  presented instruction
waiting  out  1  1 = current_pc/inst not valid; IF/ID must hold

Behaviour:
- Registers: pc (next fetch address), pc_buf, inst_buf, state. current_pc=pc_buf, inst=inst_buf.
- Reset (asynchronous): pc=RESET_PC, pc_buf=RESET_PC, inst_buf=NOP_INST, state=REQ, waiting=1.
- States: REQ, WAIT, DISCARD, HOLD.
- REQ: imem_req=1, imem_addr=pc.
  - imem_req&imem_gnt -> WAIT.
  - Without gnt, req and addr stay stable unless jb.
- WAIT: imem_req=0. imem_rvalid -> inst_buf=imem_rdata, pc_buf=pc; go to HOLD. Response latency is >=1 cycle after the grant.
- HOLD: waiting=0.
  - !stall&!jb: instruction consumed this edge; pc<=pc+4; go to REQ.
  - stall: hold everything.
- DISCARD: imem_req=0. imem_rvalid -> data dropped; go to REQ.
- waiting=1 in REQ/WAIT/DISCARD and 0 only in HOLD. Without FETCH_BYPASS_EN, outputs hold their last values while waiting=1.
- Redirect (jb=1): pc<={jb_target[63:2],2'b00}. jb has priority over stall. State effect:
  - REQ without gnt -> stay in REQ; the new address is driven next cycle.
  - REQ with gnt in the same cycle -> DISCARD (the old-address request is in flight).
  - WAIT without rvalid -> DISCARD.
  - WAIT with rvalid in the same cycle -> data dropped; go to REQ.
  - DISCARD -> stay in DISCARD; pc updated.
  - HOLD -> buffer invalidated; go to REQ.
- imem_rvalid in REQ or HOLD is a protocol violation and is ignored.
- PC arithmetic is 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Throughput without bypass: one instruction per 3 cycles with gnt=1 and 1-cycle response latency.

Optional Feature:
FETCH_BYPASS_EN.
- Defined: in WAIT with imem_rvalid & !jb, current_pc=pc and inst=imem_rdata are driven combinationally, with waiting=0 that cycle.
  - !stall: the instruction is consumed that edge; pc<=pc+4; go to REQ, skipping HOLD.
  - stall: capture into the buffer and go to HOLD as normal.
- Not defined: behaviour exactly as above; outputs are purely registered.

Test Plan:
1. Release reset with RESET_PC=0, gnt=1, rdata=32'h00500093 one cycle after the grant -> imem_req=1 with addr 0; next cycle WAIT; then HOLD with waiting=0, inst=32'h00500093, current_pc=0; next request addr=4.
2. stall=1 for 3 cycles in HOLD -> waiting=0 and outputs unchanged, imem_req=0; on release the next request is addr 4.
3. jb=1 with jb_target=64'h103 in WAIT, rvalid two cycles later with 32'hDEADBEEF -> data never presented, waiting stays 1, next imem_addr=64'h100.
4. jb and imem_gnt in the same cycle at addr 8 -> DISCARD; the following rvalid is dropped; next request addr=jb_target. Also jb in the same cycle as rvalid -> direct return to REQ.
5. gnt withheld 5 cycles -> imem_req=1 and imem_addr stable for all 5 cycles; a single WAIT follows the grant.
6. Assert rst asynchronously mid-WAIT -> outputs immediately RESET_PC/NOP_INST, waiting=1, state REQ. With FETCH_BYPASS_EN, case 1 presents inst in the rvalid cycle (2-cycle throughput).
